// File: rtl/ps_pkg.sv
// Shared definitions for the program-sequencer fetch slice.
package ps_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned STCKY_W    = 4;

  // Bit positions inside the {underflow, overflow, full, empty} status word
  localparam int unsigned STK_EMPTY = 0;
  localparam int unsigned STK_FULL  = 1;
  localparam int unsigned STK_OVF   = 2;
  localparam int unsigned STK_UNF   = 3;

endpackage

// File: rtl/ps_pc_stack.sv
// PC stack: storage, fill pointer, empty/full flags and sticky overflow/underflow bits.
module ps_pc_stack
  import ps_pkg::*;
#(
  parameter  int unsigned ADDR_W    = ADDR_W_DEF,
  parameter  int unsigned STK_DEPTH = 4,
  localparam int unsigned PTR_W     = $clog2(STK_DEPTH + 1)
) (
  input  logic              clk_fetch,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] push_dt_i,
  input  logic [ADDR_W-1:0] wr_dt_i,
  input  logic              stcky_clr_i,
  output logic [ADDR_W-1:0] tos_o,
  output logic [PTR_W-1:0]  ptr_o,
  output logic [STCKY_W-1:0] stcky_o
);

  localparam int unsigned IDX_W = $clog2(STK_DEPTH);

  logic [ADDR_W-1:0]  mem_q [STK_DEPTH];
  logic [ADDR_W-1:0]  mem_d [STK_DEPTH];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [STCKY_W-1:0] stcky_q, stcky_d;

  logic             not_empty, is_full;
  logic             ovf_set, unf_set;
  logic [IDX_W-1:0] top_idx, push_idx;

  assign not_empty = (ptr_q != '0);
  assign is_full   = (ptr_q == PTR_W'(STK_DEPTH));
  assign top_idx   = IDX_W'(ptr_q - PTR_W'(1));
  assign push_idx  = IDX_W'(ptr_q);

  // Push+pop on an empty stack falls through to the push-only branch
  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push_i && pop_i && not_empty) begin
      mem_d[top_idx] = push_dt_i;
    end else if (push_i) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        mem_d[push_idx] = push_dt_i;
        ptr_d           = ptr_q + PTR_W'(1);
      end
    end else if (pop_i) begin
      if (not_empty) begin
        ptr_d = ptr_q - PTR_W'(1);
      end else begin
        unf_set = 1'b1;
      end
    end else if (wr_i && not_empty) begin
      mem_d[top_idx] = wr_dt_i;
    end
  end

  always_comb begin
    stcky_d            = '0;
    stcky_d[STK_EMPTY] = (ptr_d == '0);
    stcky_d[STK_FULL]  = (ptr_d == PTR_W'(STK_DEPTH));
    stcky_d[STK_OVF]   = (stcky_q[STK_OVF] & ~stcky_clr_i) | ovf_set;
    stcky_d[STK_UNF]   = (stcky_q[STK_UNF] & ~stcky_clr_i) | unf_set;
  end

  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      mem_q   <= '{default: '0};
      ptr_q   <= '0;
      stcky_q <= STCKY_W'(1) << STK_EMPTY;
    end else begin
      mem_q   <= mem_d;
      ptr_q   <= ptr_d;
      stcky_q <= stcky_d;
    end
  end

  assign tos_o   = not_empty ? mem_q[top_idx] : '0;
  assign ptr_o   = ptr_q;
  assign stcky_o = stcky_q;

endmodule

// File: rtl/ps_fetch_seq.sv
// Program-sequencer fetch engine: fetch-address mux/register, halt and PM chip select around the PC stack.
module ps_fetch_seq
  import ps_pkg::*;
#(
  parameter  int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter  int unsigned       STK_DEPTH = 4,
  parameter  logic [ADDR_W-1:0] RST_VEC   = '0,
  localparam int unsigned       PTR_W     = $clog2(STK_DEPTH + 1)
) (
  input  logic              clk_fetch,
  input  logic              rst,
  input  logic              fs_idle,
  input  logic              fs_jmp,
  input  logic [ADDR_W-1:0] fs_jmp_add,
  input  logic              fs_call,
  input  logic [ADDR_W-1:0] fs_ret_add,
  input  logic              fs_rtrn,
  input  logic              fs_push,
  input  logic              fs_pop,
  input  logic              fs_stk_wr,
  input  logic [ADDR_W-1:0] fs_wr_dt,
  input  logic              fs_stcky_clr,
  output logic [ADDR_W-1:0] fs_faddr,
  output logic              fs_pm_cslt,
  output logic [ADDR_W-1:0] fs_tos,
  output logic [PTR_W-1:0]  fs_ptr,
  output logic [3:0]        fs_stcky
);

  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic              halt;
  logic              push_ev, pop_ev, wr_ev;
  logic [ADDR_W-1:0] push_dt;

  assign halt    = fs_stcky[STK_OVF] | fs_stcky[STK_UNF];
  assign push_ev = ~halt & (fs_call | fs_push);
  assign pop_ev  = ~halt & (fs_rtrn | fs_pop);
  assign wr_ev   = ~halt & fs_stk_wr;
  assign push_dt = fs_call ? fs_ret_add : fs_wr_dt;

  ps_pc_stack #(
    .ADDR_W    (ADDR_W),
    .STK_DEPTH (STK_DEPTH)
  ) u_pc_stack (
    .clk_fetch   (clk_fetch),
    .rst         (rst),
    .push_i      (push_ev),
    .pop_i       (pop_ev),
    .wr_i        (wr_ev),
    .push_dt_i   (push_dt),
    .wr_dt_i     (fs_wr_dt),
    .stcky_clr_i (fs_stcky_clr),
    .tos_o       (fs_tos),
    .ptr_o       (fs_ptr),
    .stcky_o     (fs_stcky)
  );

  // A return on an empty stack does not redirect; the underflow it raises halts fetch
  always_comb begin
    faddr_d = faddr_q;
    if (!halt) begin
      if (fs_call || fs_jmp) begin
        faddr_d = fs_jmp_add;
      end else if (fs_rtrn && (fs_ptr != '0)) begin
        faddr_d = fs_tos;
      end else if (!fs_idle) begin
        faddr_d = faddr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_fetch or negedge rst) begin
    if (!rst) begin
      faddr_q <= RST_VEC;
    end else begin
      faddr_q <= faddr_d;
    end
  end

  assign fs_faddr   = faddr_q;
  assign fs_pm_cslt = ~fs_idle & ~halt;

endmodule
